store_split_unit: RTL



---
 rtl/store_split_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/store_split_unit.sv
// Sequential store aligner: one request at a time, split into up to two bus beats.
// Optional macro MISALIGN_TRAP_EN rejects any store not naturally aligned to its size.
module store_split_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_data,
  input  logic [1:0]            req_size,
  output logic                  req_done,
  output logic                  req_err,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  output logic [DATA_W-1:0]     bus_wdata
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTES-1:0]    strb_q, strb_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [BYTES-1:0]    hi_strb_q, hi_strb_d;
  logic [DATA_W-1:0]   hi_data_q, hi_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  int unsigned         nb;
  logic [OFF_W-1:0]    off;
  logic                size_bad;
  logic                misalign;
  logic                reject;
  logic [2*BYTES-1:0]  wide_strb;
  logic [2*DATA_W-1:0] wide_data;
  logic [ADDR_W-1:0]   base;

  // Alignment over a double-width window; the upper half feeds a possible second beat.
  always_comb begin
    nb        = 32'd1 << req_size;
    off       = req_addr[OFF_W-1:0];
    size_bad  = nb > BYTES;
`ifdef MISALIGN_TRAP_EN
    misalign  = (off & OFF_W'(nb - 1)) != '0;
`else
    misalign  = 1'b0;
`endif
    reject    = size_bad | misalign;
    wide_strb = '0;
    wide_data = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (i < nb) begin
        wide_strb[i]         = 1'b1;
        wide_data[8*i +: 8]  = req_data[8*i +: 8];
      end
    end
    wide_strb = wide_strb << off;
    wide_data = wide_data << {off, 3'b000};
    base      = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    strb_d    = strb_q;
    data_d    = data_q;
    hi_strb_d = hi_strb_q;
    hi_data_d = hi_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d   = BEAT0;
            addr_d    = base;
            strb_d    = wide_strb[BYTES-1:0];
            data_d    = wide_data[DATA_W-1:0];
            hi_strb_d = wide_strb[2*BYTES-1:BYTES];
            hi_data_d = wide_data[2*DATA_W-1:DATA_W];
          end
        end
      end
      BEAT0: begin
        if (bus_ready) begin
          if (hi_strb_q != '0) begin
            state_d = BEAT1;
            addr_d  = addr_q + ADDR_W'(BYTES);
            strb_d  = hi_strb_q;
            data_d  = hi_data_q;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (bus_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      strb_q    <= '0;
      data_q    <= '0;
      hi_strb_q <= '0;
      hi_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      strb_q    <= strb_d;
      data_q    <= data_d;
      hi_strb_q <= hi_strb_d;
      hi_data_q <= hi_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // bus_valid decodes the state register so an async reset drops it at once.
  assign req_ready = (state_q == IDLE);
  assign bus_valid = (state_q != IDLE);
  assign bus_addr  = addr_q;
  assign bus_wstrb = strb_q;
  assign bus_wdata = data_q;
  assign req_done  = done_q;
  assign req_err   = err_q;

endmodule
